// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port, two combinational
// read ports, optional hardwired x0, optional write-to-read bypass and a sequenced clear.
module reg_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2,
    input  logic             clr,
    output logic             busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t             r_state;
    logic [AW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_wr_en;
    logic               w_byp1;
    logic               w_byp2;

    // An address is usable when it is in range and is not the hardwired x0.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = (32'(a) < 32'(DEPTH));
        is_zero  = (ZERO_REG != 0) && (a == AW'(0));
        return in_range && !is_zero;
    endfunction

    assign w_wr_en = we && (r_state == S_IDLE) && addr_ok(waddr);
    assign w_byp1  = (BYPASS != 0) && w_wr_en && (waddr == raddr1);
    assign w_byp2  = (BYPASS != 0) && w_wr_en && (waddr == raddr2);

    // Clear sequencer: walks r_cnt over every entry, busy mirrors the sweep state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= AW'(0);
            busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr) begin
                        r_state <= S_SWEEP;
                        r_cnt   <= AW'(0);
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= AW'(0);
                        busy    <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (r_cnt == LAST_IDX) begin
                        r_state <= S_IDLE;
                        r_cnt   <= AW'(0);
                        busy    <= 1'b0;
                    end else begin
                        r_state <= S_SWEEP;
                        r_cnt   <= r_cnt + AW'(1);
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= AW'(0);
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: the sweep has priority, writes are only taken while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (r_state == S_SWEEP) begin
            r_mem[r_cnt] <= {WIDTH{1'b0}};
        end else if (w_wr_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port 1.
    always_comb begin
        rdata1 = {WIDTH{1'b0}};
        if (rst) begin
            rdata1 = {WIDTH{1'b0}};
        end else if (w_byp1) begin
            rdata1 = wdata;
        end else if (addr_ok(raddr1)) begin
            rdata1 = r_mem[raddr1];
        end else begin
            rdata1 = {WIDTH{1'b0}};
        end
    end

    // Read port 2.
    always_comb begin
        rdata2 = {WIDTH{1'b0}};
        if (rst) begin
            rdata2 = {WIDTH{1'b0}};
        end else if (w_byp2) begin
            rdata2 = wdata;
        end else if (addr_ok(raddr2)) begin
            rdata2 = r_mem[raddr2];
        end else begin
            rdata2 = {WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: three instances (bypass/DEPTH=32, no bypass/DEPTH=32,
// bypass/DEPTH=24) share one stimulus stream and are checked against a reference model.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        clr;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;
    logic        busy_a, busy_b, busy_c;

    reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_a), .raddr2(raddr2), .rdata2(rd2_a),
        .clr(clr), .busy(busy_a)
    );

    reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_b), .raddr2(raddr2), .rdata2(rd2_b),
        .clr(clr), .busy(busy_b)
    );

    reg_file #(.WIDTH(32), .DEPTH(24), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rd1_c), .raddr2(raddr2), .rdata2(rd2_c),
        .clr(clr), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, one slot per instance.
    logic [31:0] m_mem [3][32];
    bit          m_sweep [3];
    int          m_cnt [3];
    int          m_depth [3] = '{32, 32, 24};
    bit          m_byp [3]   = '{1'b1, 1'b0, 1'b1};

    logic [31:0] sb_q [$];
    string       tag_q [$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          bc [3];
    bit          count_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 32; a++) m_mem[i][a] = 32'h0;
            m_sweep[i] = 1'b0;
            m_cnt[i]   = 0;
        end
    endfunction

    function automatic logic [31:0] model_rd(input int i, input logic [4:0] a);
        if (rst) return 32'h0;
        if (int'(a) >= m_depth[i] || a == 5'd0) return 32'h0;
        if (m_byp[i] && !m_sweep[i] && we && waddr == a) return wdata;
        return m_mem[i][a];
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!m_sweep[i]) begin
                if (we && int'(waddr) < m_depth[i] && waddr != 5'd0) m_mem[i][waddr] = wdata;
                if (clr) begin
                    m_sweep[i] = 1'b1;
                    m_cnt[i]   = 0;
                end
            end else begin
                m_mem[i][m_cnt[i]] = 32'h0;
                if (m_cnt[i] == m_depth[i] - 1) begin
                    m_sweep[i] = 1'b0;
                    m_cnt[i]   = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
    endfunction

    function automatic logic [31:0] dut_out(input int i, input int k);
        case (i)
            0:       return (k == 0) ? rd1_a : (k == 1) ? rd2_a : {31'h0, busy_a};
            1:       return (k == 0) ? rd1_b : (k == 1) ? rd2_b : {31'h0, busy_b};
            default: return (k == 0) ? rd1_c : (k == 1) ? rd2_c : {31'h0, busy_c};
        endcase
    endfunction

    // One clock cycle: drive, predict, compare mid-cycle, advance model at the edge.
    task automatic cycle(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2, input bit c);
        string nm [3];
        nm = '{"a", "b", "c"};
        rst = r; we = w; waddr = wa; wdata = wd; raddr1 = ra1; raddr2 = ra2; clr = c;
        if (rst) model_reset();
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(model_rd(i, ra1));             tag_q.push_back({"rdata1_", nm[i]});
            sb_q.push_back(model_rd(i, ra2));             tag_q.push_back({"rdata2_", nm[i]});
            sb_q.push_back({31'h0, m_sweep[i] && !rst});  tag_q.push_back({"busy_", nm[i]});
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                check_val(tag_q.pop_front(), dut_out(i, k), sb_q.pop_front());
            end
            if (count_en && dut_out(i, 2) == 32'd1) bc[i]++;
        end
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
    endtask

    function automatic logic [31:0] pat(input int a);
        return {16'hC0DE, 11'h0, 5'(a)};
    endfunction

    initial begin
        rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        raddr1 = 5'd0; raddr2 = 5'd0; clr = 1'b0;
        model_reset();

        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b0);

        // Fill, then hold reset and scan every address.
        for (int a = 1; a < 32; a++) cycle(1'b0, 1'b1, 5'(a), pat(a), 5'(a), 5'(a - 1), 1'b0);
        for (int a = 0; a < 32; a++) cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1'b0);
        for (int a = 1; a < 5; a++)  cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(a + 10), 1'b0);

        // Write/read, x0 write, bypass on both ports, bypass of x0.
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0);
        cycle(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0);
        cycle(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0);
        cycle(1'b0, 1'b1, 5'd0, 32'hA5A5A5A5, 5'd0, 5'd0, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0);

        // Address 27 is out of range for the 24-entry instance only.
        cycle(1'b0, 1'b1, 5'd27, 32'hFFFF0027, 5'd27, 5'd26, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd27, 5'd23, 1'b0);

        // Full sweep with a write and a second clr issued while busy.
        for (int a = 1; a < 32; a++) cycle(1'b0, 1'b1, 5'(a), pat(a) ^ 32'h00FF0000, 5'(a), 5'd10, 1'b0);
        bc = '{0, 0, 0};
        count_en = 1'b1;
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd3, 1'b1);
        for (int k = 0; k < 40; k++) begin
            cycle(1'b0, (k == 3), 5'd3, 32'h33333333, 5'd10, 5'(k % 32), (k == 8));
        end
        count_en = 1'b0;
        check_val("busy_len_a", 32'(bc[0]), 32'd32);
        check_val("busy_len_b", 32'(bc[1]), 32'd32);
        check_val("busy_len_c", 32'(bc[2]), 32'd24);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd10, 1'b0);

        // Reset five cycles into a sweep, then a write after release.
        for (int a = 1; a < 12; a++) cycle(1'b0, 1'b1, 5'(a), pat(a), 5'(a), 5'd11, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 1'b0);
        cycle(1'b0, 1'b1, 5'd9, 32'h99990009, 5'd8, 5'd9, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd8, 1'b0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 40) == 0));
        end

        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised general-purpose register file for the RISC-V 32-bit CPU, the successor to the single 32-bit `register` block. It provides one synchronous write port and two combinational read ports, an optional hardwired-zero entry 0 (x0), optional write-to-read bypass, and a sequenced clear that zeroes every entry one per cycle. It sits between decode, which supplies the read addresses, and writeback, which supplies the write port.

## Interface
- WIDTH, 32, data width of each entry.
- DEPTH, 32, number of entries; any value ≥ 2, not necessarily a power of two.
- AW, $clog2(DEPTH), address width (derived; do not override).
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to that read port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr1  in  AW  read port 1 address.
- rdata1  out  WIDTH  read port 1 data (combinational).
- raddr2  in  AW  read port 2 address.
- rdata2  out  WIDTH  read port 2 data (combinational).
- clr  in  1  clear request, single-cycle pulse or level.
- busy  out  1  clear sweep in progress (registered).

## Operation
- Reset (rst high, asynchronous): all entries = 0, state = IDLE, sweep counter = 0, busy = 0. rdata1 and rdata2 read 0 while rst is held.
- Write: at a rising edge with we=1, state=IDLE, and waddr < DEPTH, entry[waddr] ← wdata. When ZERO_REG=1 and waddr=0, the write is dropped.
- Out-of-range addresses (≥ DEPTH): writes are ignored and reads return 0.
- Read: rdataN = entry[raddrN]. It is forced to 0 when ZERO_REG=1 and raddrN=0, or when raddrN is out of range.
- Bypass (BYPASS=1, state=IDLE): if we=1, waddr=raddrN, and the write is legal (in range, not x0 when ZERO_REG=1), then rdataN = wdata in that same cycle. Both ports may bypass at once.
- BYPASS=0: a read returns the pre-edge contents; the new value appears the cycle after the write.
- Clear FSM:
  - IDLE: clr=1 at an edge moves to SWEEP with counter = 0. A we in that same cycle is still performed.
  - SWEEP: each edge does entry[counter] ← 0 and counter += 1. When counter = DEPTH-1 at an edge, that entry is cleared, the FSM returns to IDLE, and counter returns to 0.
  - In SWEEP: we is ignored and bypass is disabled. Reads return current array contents, so swept entries read 0 and unswept entries keep their old values. clr is ignored.
- busy = (state == SWEEP).
- rst during SWEEP: the sweep aborts immediately and all entries go to 0.

## Timing
- Read latency is 0 cycles (combinational from raddr, and from we/waddr/wdata when bypass is active).
- Write latency is 1 edge; the non-bypassed read shows the new value in the cycle after the edge.
- Clear timing, with clr sampled at edge N:
  - busy rises after edge N.
  - Entry k is cleared at edge N+1+k.
  - busy falls after edge N+DEPTH, so it is high for exactly DEPTH cycles.
- A write is accepted again starting at edge N+DEPTH+1.
- No combinational path from clr to busy.

## Test plan
- Reset: hold rst with prior contents present → every address on both ports reads 0 and busy = 0. Release rst → values unchanged.
- Write/read with BYPASS=0: write 0xDEADBEEF to entry 5 → rdata1 (raddr1=5) stays at its old value during the write cycle and reads 0xDEADBEEF the next cycle. Writing 0x12345678 to entry 0 → entry 0 still reads 0.
- Bypass, BYPASS=1, both ports: we=1, waddr=7, wdata=0xA5A5A5A5, raddr1=raddr2=7 → both ports read 0xA5A5A5A5 in the same cycle. With waddr=0 in the same setup → both ports read 0.
- Clear sweep, DEPTH=32:
  - Fill entries 1..31 with a non-zero pattern, then pulse clr.
  - busy must be high for exactly 32 cycles.
  - Entry 10 reads non-zero until edge N+11, then reads 0.
  - A we issued during busy is lost.
  - A second clr during busy has no effect.
- Reset mid-sweep: assert rst 5 cycles into a sweep → busy drops immediately, all entries read 0, and a write issued after rst is released succeeds.
- Non-power-of-two: DEPTH=24, AW=5 → a write to address 27 is ignored, a read of address 27 returns 0, and a sweep lasts exactly 24 cycles.
